// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap controller: CSR addresses, sstatus bit positions,
// cause codes and FSM encodings.
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_SSTATUS = 12'h100;
  localparam logic [11:0] CSR_STVEC   = 12'h105;
  localparam logic [11:0] CSR_SEPC    = 12'h141;
  localparam logic [11:0] CSR_SCAUSE  = 12'h142;

  localparam int unsigned SIE_BIT  = 1;
  localparam int unsigned SPIE_BIT = 5;

  localparam logic [7:0] CAUSE_MISALIGN = 8'h00;
  localparam logic [7:0] CAUSE_ILLEGAL  = 8'h02;
  localparam logic [7:0] CAUSE_ECALL    = 8'h08;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ENTER  = 2'd1;
  localparam logic [1:0] ST_RETURN = 2'd2;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/trap_csr_file.sv
// Supervisor trap CSRs (sstatus/stvec/sepc/scause): trap/return side effects, masked
// software writes and the combinational read mux. Exports SIE only when TRAP_EXT_IRQ_EN is set.
module trap_csr_file
  import trap_ctrl_pkg::*;
#(
  parameter logic [31:0] STVEC_RST = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        trap_take,
  input  logic [31:0] trap_pc,
  input  logic [7:0]  trap_cause,
  input  logic        ret_take,
  input  logic        csr_wr,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
`ifdef TRAP_EXT_IRQ_EN
  output logic        sie,
`endif
  output logic [31:0] csr_rdata,
  output logic [31:0] sepc,
  output logic [31:0] stvec
);

  logic [31:0] sepc_q, stvec_q;
  logic [7:0]  scause_q;
  logic        sie_q, spie_q;

  // Priority: trap entry, then return, then software write; the caller already
  // guarantees csr_wr is never high together with trap_take or ret_take.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sepc_q   <= 32'h0;
      stvec_q  <= STVEC_RST;
      scause_q <= 8'h0;
      sie_q    <= 1'b0;
      spie_q   <= 1'b0;
    end else if (trap_take) begin
      sepc_q   <= trap_pc;
      scause_q <= trap_cause;
      spie_q   <= sie_q;
      sie_q    <= 1'b0;
    end else if (ret_take) begin
      sie_q  <= spie_q;
      spie_q <= 1'b1;
    end else if (csr_wr) begin
      case (csr_addr)
        CSR_SSTATUS: begin
          sie_q  <= csr_wdata[SIE_BIT];
          spie_q <= csr_wdata[SPIE_BIT];
        end
        CSR_STVEC:  stvec_q  <= word_align(csr_wdata);
        CSR_SEPC:   sepc_q   <= word_align(csr_wdata);
        CSR_SCAUSE: scause_q <= csr_wdata[7:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    csr_rdata = 32'h0;
    case (csr_addr)
      CSR_SSTATUS: begin
        csr_rdata[SIE_BIT]  = sie_q;
        csr_rdata[SPIE_BIT] = spie_q;
      end
      CSR_STVEC:  csr_rdata = stvec_q;
      CSR_SEPC:   csr_rdata = sepc_q;
      CSR_SCAUSE: csr_rdata = {24'h0, scause_q};
      default:    csr_rdata = 32'h0;
    endcase
  end

  assign sepc  = sepc_q;
  assign stvec = stvec_q;
`ifdef TRAP_EXT_IRQ_EN
  assign sie   = sie_q;
`endif

endmodule

// File: rtl/trap_ctrl.sv
// Trap controller: IDLE/ENTER/RETURN sequencing, trap/return/CSR-write priority and the
// fetch redirect. Optional external interrupt entry is enabled by defining TRAP_EXT_IRQ_EN.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [31:0] STVEC_RST = 32'h0000_0100,
  parameter logic [6:0]  IRQ_CODE  = 7'd9
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        exc_valid,
  input  logic [7:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic        mret,
`ifdef TRAP_EXT_IRQ_EN
  input  logic        irq,
  input  logic        pc_valid,
`endif
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        busy
);

  logic [1:0]  state_q, state_d;
  logic        idle;
  logic        irq_take;
  logic        trap_take;
  logic        ret_take;
  logic        csr_wr;
  logic [7:0]  trap_cause;
  logic [31:0] sepc, stvec;

  assign idle = (state_q == ST_IDLE);

`ifdef TRAP_EXT_IRQ_EN
  logic sie;
  // Interrupts yield to both synchronous exceptions and mret in the same cycle.
  assign irq_take = idle & sie & irq & pc_valid & ~exc_valid & ~mret;
`else
  assign irq_take = 1'b0;
`endif

  assign trap_take  = idle & (exc_valid | irq_take);
  assign ret_take   = idle & mret & ~exc_valid;
  assign csr_wr     = idle & csr_we & ~trap_take & ~mret;
  assign trap_cause = irq_take ? {1'b1, IRQ_CODE} : exc_cause;

  trap_csr_file #(
    .STVEC_RST (STVEC_RST)
  ) u_csr (
    .clk        (clk),
    .rstn       (rstn),
    .trap_take  (trap_take),
    .trap_pc    (exc_pc),
    .trap_cause (trap_cause),
    .ret_take   (ret_take),
    .csr_wr     (csr_wr),
    .csr_addr   (csr_addr),
    .csr_wdata  (csr_wdata),
`ifdef TRAP_EXT_IRQ_EN
    .sie        (sie),
`endif
    .csr_rdata  (csr_rdata),
    .sepc       (sepc),
    .stvec      (stvec)
  );

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (trap_take) begin
          state_d = ST_ENTER;
        end else if (ret_take) begin
          state_d = ST_RETURN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs decode registered state only; stvec/sepc cannot change while non-idle.
  assign redirect = ~idle;
  assign flush    = ~idle;
  assign busy     = ~idle;

  always_comb begin
    redirect_pc = 32'h0;
    case (state_q)
      ST_ENTER:  redirect_pc = word_align(stvec);
      ST_RETURN: redirect_pc = sepc;
      default:   redirect_pc = 32'h0;
    endcase
  end

endmodule
